// File: rtl/sd_spi_pkg.sv
// sd_spi_pkg -- shared definitions for the SD-card SPI byte master.
//
// Contents:
//   S_IDLE .. S_DONE  state encoding of the byte FSM (logic [2:0] constants)
//   ACT_TIMEOUT       activity-indicator hold time in clk_sys cycles
//   ACT_CNT_W         width of the activity timeout counter
//   IDLE_BYTE         value seen on an undriven / idle SD data line
//
// Optional feature macro used by the files that import this package:
//   SD_SPI_ACT_LED_EN  enables the activity-LED timeout counter.

package sd_spi_pkg;

    // Byte FSM states. The FSM walks IDLE -> LEAD -> (HIGH -> LOW) x 8 -> DONE.
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEAD = 3'd1;
    localparam logic [2:0] S_HIGH = 3'd2;
    localparam logic [2:0] S_LOW  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    // ~20 ms at 96 MHz; fits in 21 bits (2^21 = 2,097,152).
    localparam int unsigned ACT_TIMEOUT = 2_000_000;
    localparam int          ACT_CNT_W   = 21;

    // An SD card releases its data line high, so 8'hFF is the "nothing" byte.
    localparam logic [7:0] IDLE_BYTE = 8'hFF;

endpackage : sd_spi_pkg

// File: rtl/sd_spi_clkgen.sv
// sd_spi_clkgen -- SCK half-period timer for the SD SPI master.
//
// Owns the half-period down-counter. The counter is loaded with half-1 when a
// byte is accepted and then counts half-1 .. 0 repeatedly while run is high.
// Each time it reaches 0 a single-cycle strobe is raised: rise_stb when SCK is
// currently low (the FSM should raise SCK), fall_stb when SCK is currently high.
//
// Ports:
//   clk_sys    in   system clock
//   reset_n    in   asynchronous reset, active-low
//   load       in   byte accepted: latch half_in and restart the count
//   half_in    in   clk_sys cycles per SCK half-period for this byte (>= 1)
//   run        in   FSM is in a timed state (LEAD/HIGH/LOW)
//   sck_level  in   current registered SCK level
//   rise_stb   out  half-period over while SCK low
//   fall_stb   out  half-period over while SCK high

module sd_spi_clkgen #(
    parameter int CNT_W = 8
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] half_in,
    input  logic             run,
    input  logic             sck_level,
    output logic             rise_stb,
    output logic             fall_stb
);

    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic             expire;

    // The rate is frozen per byte: half_q only changes on load.
    always_comb begin
        half_d = half_q;
        cnt_d  = cnt_q;
        if (load) begin
            half_d = half_in;
            cnt_d  = half_in - CNT_W'(1);
        end else if (run) begin
            if (cnt_q == '0) begin
                cnt_d = half_q - CNT_W'(1);
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            half_q <= '1;
            cnt_q  <= '0;
        end else begin
            half_q <= half_d;
            cnt_q  <= cnt_d;
        end
    end

    // With half = 1 the counter sits at 0, so a strobe fires every cycle and
    // SCK runs at clk_sys/2.
    assign expire   = run && (cnt_q == '0);
    assign rise_stb = expire && !sck_level;
    assign fall_stb = expire &&  sck_level;

endmodule : sd_spi_clkgen

// File: rtl/sd_spi_master.sv
// sd_spi_master -- SPI mode-0 byte master for the SD card interface.
//
// Shifts one byte out MSB-first per valid/ready handshake and returns the byte
// captured on MISO. SCK idles low, MOSI idles high, chip select is driven from
// cs_req but only updated while idle.
//
// Handshake: a byte is accepted on a clk_sys edge where tx_valid && tx_ready.
// tx_ready is high only in IDLE; tx_valid while busy is ignored and tx_data is
// not needed after the accept edge. rx_valid is a one-cycle pulse in the cycle
// rx_data takes its new value; rx_data holds until the next completion.
//
// Ports:
//   clk_sys   in   system clock
//   reset_n   in   asynchronous reset, active-low
//   tx_data   in   byte to transmit
//   tx_valid  in   request to start a byte
//   tx_ready  out  idle, byte can be accepted
//   rx_data   out  last byte captured from MISO
//   rx_valid  out  one-cycle pulse when rx_data updates
//   fast      in   rate select (1 = HALF_FAST), sampled at accept
//   cs_req    in   requested chip-select (1 = selected)
//   busy      out  transfer in progress (~tx_ready)
//   spi_clk   out  SCK
//   spi_mosi  out  MOSI
//   spi_miso  in   MISO
//   spi_cs_n  out  chip select, active-low
//   sd_act    out  activity indicator
//
// Optional feature macro: SD_SPI_ACT_LED_EN. When defined, sd_act is driven by
// a timeout counter restarted by any MOSI/MISO toggle; otherwise sd_act = busy.
//
// The current FSM state is available as state_q for debug binding.

module sd_spi_master
    import sd_spi_pkg::*;
#(
    parameter int HALF_SLOW = 120,
    parameter int HALF_FAST = 2,
    parameter int CNT_W     = 8
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       fast,
    input  logic       cs_req,
    output logic       busy,
    output logic       spi_clk,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       spi_cs_n,
    output logic       sd_act
);

    logic [2:0] state_q,    state_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [2:0] bit_cnt_q,  bit_cnt_d;
    logic       last_q,     last_d;
    logic       sck_q,      sck_d;
    logic       mosi_q,     mosi_d;
    logic       cs_n_q,     cs_n_d;
    logic [7:0] rx_data_q,  rx_data_d;
    logic       rx_valid_q, rx_valid_d;

    logic             load;
    logic             run;
    logic             rise_stb;
    logic             fall_stb;
    logic [CNT_W-1:0] half_sel;

    assign half_sel = fast ? CNT_W'(HALF_FAST) : CNT_W'(HALF_SLOW);
    assign run      = (state_q == S_LEAD) || (state_q == S_HIGH) || (state_q == S_LOW);

    sd_spi_clkgen #(
        .CNT_W (CNT_W)
    ) u_clkgen (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .load      (load),
        .half_in   (half_sel),
        .run       (run),
        .sck_level (sck_q),
        .rise_stb  (rise_stb),
        .fall_stb  (fall_stb)
    );

    always_comb begin
        state_d    = state_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        bit_cnt_d  = bit_cnt_q;
        last_d     = last_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        load       = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Chip select only follows cs_req here, so it never moves mid-byte.
                cs_n_d = !cs_req;
                if (tx_valid) begin
                    load       = 1'b1;
                    tx_shift_d = tx_data;
                    mosi_d     = tx_data[7];
                    bit_cnt_d  = 3'd0;
                    last_d     = 1'b0;
                    state_d    = S_LEAD;
                end
            end

            S_LEAD: begin
                // MOSI setup half-period with SCK low, then the first rising edge.
                if (rise_stb) begin
                    rx_shift_d = {rx_shift_q[6:0], spi_miso};
                    state_d    = S_HIGH;
                end
            end

            S_HIGH: begin
                if (fall_stb) begin
                    state_d = S_LOW;
                    if (bit_cnt_q != 3'd7) begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        mosi_d     = tx_shift_q[6];
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                    end else begin
                        // Eighth falling edge: LOW lasts one cycle, no half-period.
                        last_d = 1'b1;
                    end
                end
            end

            S_LOW: begin
                if (last_q) begin
                    rx_data_d  = rx_shift_q;
                    rx_valid_d = 1'b1;
                    mosi_d     = 1'b1;
                    state_d    = S_DONE;
                end else if (rise_stb) begin
                    rx_shift_d = {rx_shift_q[6:0], spi_miso};
                    state_d    = S_HIGH;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // SCK is a registered decode of the next state so it is glitch-free.
    assign sck_d = (state_d == S_HIGH);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            tx_shift_q <= IDLE_BYTE;
            rx_shift_q <= IDLE_BYTE;
            bit_cnt_q  <= 3'd0;
            last_q     <= 1'b0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b1;
            cs_n_q     <= 1'b1;
            rx_data_q  <= IDLE_BYTE;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            bit_cnt_q  <= bit_cnt_d;
            last_q     <= last_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign tx_ready = (state_q == S_IDLE);
    assign busy     = !tx_ready;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign spi_clk  = sck_q;
    assign spi_mosi = mosi_q;
    assign spi_cs_n = cs_n_q;

`ifdef SD_SPI_ACT_LED_EN
    // Activity LED: restart the timeout on any data-line toggle; the counter
    // saturates at ACT_TIMEOUT and starts there so the LED is off after reset.
    localparam logic [ACT_CNT_W-1:0] ACT_LIMIT = ACT_CNT_W'(ACT_TIMEOUT);

    logic [ACT_CNT_W-1:0] act_cnt_q,   act_cnt_d;
    logic                 mosi_prev_q, mosi_prev_d;
    logic                 miso_prev_q, miso_prev_d;

    always_comb begin
        act_cnt_d   = act_cnt_q;
        mosi_prev_d = mosi_q;
        miso_prev_d = spi_miso;
        if ((mosi_q != mosi_prev_q) || (spi_miso != miso_prev_q)) begin
            act_cnt_d = '0;
        end else if (act_cnt_q < ACT_LIMIT) begin
            act_cnt_d = act_cnt_q + ACT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            act_cnt_q   <= ACT_LIMIT;
            mosi_prev_q <= 1'b1;
            miso_prev_q <= 1'b1;
        end else begin
            act_cnt_q   <= act_cnt_d;
            mosi_prev_q <= mosi_prev_d;
            miso_prev_q <= miso_prev_d;
        end
    end

    assign sd_act = (act_cnt_q < ACT_LIMIT);
`else
    assign sd_act = busy;
`endif

endmodule : sd_spi_master

// File: tb/tb_sd_spi_master.sv
// tb_sd_spi_master -- self-checking bench for sd_spi_master.
//
// Timing model (derived from the byte protocol, not the FSM): after the accept
// edge a byte spends h cycles of lead-in, 8 SCK-high halves, 7 SCK-low halves,
// one final low cycle, then the completion cycle carries rx_valid. Rising edge
// i lands h + 2*h*i cycles after accept, falling edge i at 2*h*(i+1).

module tb_sd_spi_master;

  localparam int HS = 120;
  localparam int HF = 2;

  logic       clk_sys;
  logic       reset_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       fast;
  logic       cs_req;
  logic       busy;
  logic       spi_clk;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_cs_n;
  logic       sd_act;

  sd_spi_master #(
    .HALF_SLOW (HS),
    .HALF_FAST (HF),
    .CNT_W     (8)
  ) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .fast     (fast),
    .cs_req   (cs_req),
    .busy     (busy),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_cs_n (spi_cs_n),
    .sd_act   (sd_act)
  );

  // ---------------- clock ----------------
  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // ---------------- counters ----------------
  int vec_cnt  = 0;
  int miss_cnt = 0;

  // ---------------- MISO models ----------------
  // mode 0: line idles high, 1: loopback from MOSI, 2: responder shifting
  // resp_byte MSB-first, advancing on each SCK falling edge.
  logic [1:0] miso_mode = 2'd0;
  logic [7:0] resp_byte = 8'hFF;
  int         fall_cnt  = 0;
  int         fall_base = 0;
  int         resp_idx;
  logic       resp_bit;

  always @(negedge spi_clk) fall_cnt <= fall_cnt + 1;

  assign resp_idx = fall_cnt - fall_base;
  assign resp_bit = (resp_idx >= 0 && resp_idx < 8) ? resp_byte[3'(7 - resp_idx)] : 1'b1;
  assign spi_miso = (miso_mode == 2'd1) ? spi_mosi :
                    (miso_mode == 2'd2) ? resp_bit : 1'b1;

  // ---------------- reference model ----------------
  function automatic int model_latency(input int h);
    return h + 8 * h + 7 * h + 1;
  endfunction

  function automatic int model_rise(input int h, input int i);
    return h + 2 * h * i;
  endfunction

  function automatic int model_fall(input int h, input int i);
    return 2 * h * (i + 1);
  endfunction

  // ---------------- driver observations ----------------
  int         obs_wait;
  int         obs_latency;
  logic [7:0] obs_rx;
  int         obs_rises;
  int         obs_falls;
  int         obs_rise_t [16];
  int         obs_fall_t [16];
  logic       obs_mosi_rise [16];
  logic       obs_mosi_pre [16];
  logic       obs_mosi_done;
  logic       obs_rxv_after;
  logic       obs_ready_after;
  logic       obs_sck_after;
  int         obs_busy_hi;
  int         obs_act_diff;
  int         obs_rdy_bad;
  int         obs_cs_hi;

  // Sends one byte and records what the pins did, one sample per negedge.
  // Sample k is the state after the k-th clock edge following accept (k=0 is
  // the accept edge). Returns at the sample right after rx_valid.
  task automatic send_byte(input logic [7:0] data, input logic f, input bit keep,
                           input logic [7:0] nxt, input bit tog_fast, input bit drop_cs);
    logic prev_sck;
    logic prev_mosi;
    int   nr;
    int   nf;
    tx_data  = data;
    tx_valid = 1'b1;
    fast     = f;
    obs_wait = 0;
    while (tx_ready !== 1'b1 && obs_wait < 5000) begin
      @(negedge clk_sys);
      obs_wait++;
    end
    fall_base = fall_cnt;
    prev_sck  = spi_clk;
    prev_mosi = spi_mosi;
    @(posedge clk_sys);
    @(negedge clk_sys);
    if (keep) begin
      tx_data = nxt;
    end else begin
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
    end
    nr = 0; nf = 0;
    obs_latency = -1; obs_rx = 8'h00; obs_mosi_done = 1'b0;
    obs_busy_hi = 0; obs_act_diff = 0; obs_rdy_bad = 0; obs_cs_hi = 0;
    for (int i = 0; i < 16; i++) begin
      obs_rise_t[i] = -1; obs_fall_t[i] = -1;
      obs_mosi_rise[i] = 1'bx; obs_mosi_pre[i] = 1'bx;
    end
    for (int k = 0; k < 4000; k++) begin
      if (k > 0) @(negedge clk_sys);
      if (tog_fast) fast = 1'($urandom);
      if (drop_cs && k == 5) cs_req = 1'b0;
      if (spi_clk === 1'b1 && prev_sck === 1'b0) begin
        if (nr < 16) begin
          obs_rise_t[nr]    = k;
          obs_mosi_rise[nr] = spi_mosi;
          obs_mosi_pre[nr]  = prev_mosi;
        end
        nr++;
      end
      if (spi_clk === 1'b0 && prev_sck === 1'b1) begin
        if (nf < 16) obs_fall_t[nf] = k;
        nf++;
      end
      if (busy === 1'b1) obs_busy_hi++;
      if (sd_act !== busy) obs_act_diff++;
      if (tx_ready === busy) obs_rdy_bad++;
      if (spi_cs_n !== 1'b0) obs_cs_hi++;
      prev_sck  = spi_clk;
      prev_mosi = spi_mosi;
      if (rx_valid === 1'b1) begin
        obs_latency   = k;
        obs_rx        = rx_data;
        obs_mosi_done = spi_mosi;
        break;
      end
    end
    obs_rises = nr;
    obs_falls = nf;
    @(negedge clk_sys);
    obs_rxv_after   = rx_valid;
    obs_ready_after = tx_ready;
    obs_sck_after   = spi_clk;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    tx_data = 8'h00; tx_valid = 1'b0; fast = 1'b1; cs_req = 1'b0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    vec_cnt++; if (spi_clk !== 1'b0)     begin miss_cnt++; $display("FAIL rst_sck got %b want 0", spi_clk); end
    vec_cnt++; if (spi_mosi !== 1'b1)    begin miss_cnt++; $display("FAIL rst_mosi got %b want 1", spi_mosi); end
    vec_cnt++; if (spi_cs_n !== 1'b1)    begin miss_cnt++; $display("FAIL rst_cs_n got %b want 1", spi_cs_n); end
    vec_cnt++; if (tx_ready !== 1'b1)    begin miss_cnt++; $display("FAIL rst_ready got %b want 1", tx_ready); end
    vec_cnt++; if (busy !== 1'b0)        begin miss_cnt++; $display("FAIL rst_busy got %b want 0", busy); end
    vec_cnt++; if (rx_valid !== 1'b0)    begin miss_cnt++; $display("FAIL rst_rx_valid got %b want 0", rx_valid); end
    vec_cnt++; if (rx_data !== 8'hFF)    begin miss_cnt++; $display("FAIL rst_rx_data got %h want ff", rx_data); end
    vec_cnt++; if (sd_act !== 1'b0)      begin miss_cnt++; $display("FAIL rst_sd_act got %b want 0", sd_act); end
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);
    vec_cnt++; if (tx_ready !== 1'b1 || spi_clk !== 1'b0) begin
      miss_cnt++; $display("FAIL post_rst_idle got ready=%b sck=%b want 1/0", tx_ready, spi_clk);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] d;
    int         bad;
    d = 8'hA5;
    miso_mode = 2'd1;
    cs_req    = 1'b1;
    @(negedge clk_sys);
    send_byte(d, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    vec_cnt++; if (obs_latency !== model_latency(HF)) begin
      miss_cnt++; $display("FAIL lb_latency got %0d want %0d", obs_latency, model_latency(HF));
    end
    vec_cnt++; if (obs_rx !== d) begin miss_cnt++; $display("FAIL lb_rx got %h want %h", obs_rx, d); end
    vec_cnt++; if (obs_rises !== 8) begin miss_cnt++; $display("FAIL lb_rises got %0d want 8", obs_rises); end
    vec_cnt++; if (obs_falls !== 8) begin miss_cnt++; $display("FAIL lb_falls got %0d want 8", obs_falls); end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (obs_rise_t[i] != model_rise(HF, i)) bad++;
      if (obs_fall_t[i] != model_fall(HF, i)) bad++;
    end
    vec_cnt++; if (bad !== 0) begin miss_cnt++; $display("FAIL lb_edge_timing got %0d bad edges want 0", bad); end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (obs_mosi_rise[i] !== d[7 - i]) bad++;
      if (obs_mosi_pre[i] !== d[7 - i]) bad++;
    end
    vec_cnt++; if (bad !== 0) begin miss_cnt++; $display("FAIL lb_mosi_bits got %0d bad bits want 0", bad); end
    vec_cnt++; if (obs_mosi_done !== 1'b1) begin miss_cnt++; $display("FAIL lb_mosi_done got %b want 1", obs_mosi_done); end
    vec_cnt++; if (obs_rxv_after !== 1'b0) begin miss_cnt++; $display("FAIL lb_rxv_pulse got %b want 0", obs_rxv_after); end
    vec_cnt++; if (obs_ready_after !== 1'b1) begin miss_cnt++; $display("FAIL lb_ready_after got %b want 1", obs_ready_after); end
    vec_cnt++; if (obs_busy_hi !== model_latency(HF) + 1) begin
      miss_cnt++; $display("FAIL lb_busy_cycles got %0d want %0d", obs_busy_hi, model_latency(HF) + 1);
    end
    vec_cnt++; if (obs_rdy_bad !== 0) begin miss_cnt++; $display("FAIL lb_ready_vs_busy got %0d want 0", obs_rdy_bad); end
`ifdef SD_SPI_ACT_LED_EN
    vec_cnt++; if (sd_act !== 1'b1) begin miss_cnt++; $display("FAIL lb_sd_act got %b want 1", sd_act); end
`else
    vec_cnt++; if (obs_act_diff !== 0) begin miss_cnt++; $display("FAIL lb_act_eq_busy got %0d want 0", obs_act_diff); end
`endif
  endtask

  task automatic test_slow_rate();
    logic [7:0] d;
    int         bad;
    d = 8'h40;
    miso_mode = 2'd1;
    @(negedge clk_sys);
    send_byte(d, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    fast = 1'b1;
    vec_cnt++; if (obs_latency !== model_latency(HS)) begin
      miss_cnt++; $display("FAIL slow_latency got %0d want %0d", obs_latency, model_latency(HS));
    end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (obs_rise_t[i] != model_rise(HS, i)) bad++;
      if (obs_fall_t[i] != model_fall(HS, i)) bad++;
    end
    vec_cnt++; if (bad !== 0) begin miss_cnt++; $display("FAIL slow_edge_timing got %0d bad edges want 0", bad); end
    vec_cnt++; if (obs_rx !== d) begin miss_cnt++; $display("FAIL slow_rx got %h want %h", obs_rx, d); end
  endtask

  task automatic test_responder_cs();
    miso_mode = 2'd2;
    resp_byte = 8'h01;
    cs_req    = 1'b0;
    repeat (2) @(negedge clk_sys);
    vec_cnt++; if (spi_cs_n !== 1'b1) begin miss_cnt++; $display("FAIL cs_idle got %b want 1", spi_cs_n); end
    cs_req = 1'b1;
    #1;
    vec_cnt++; if (spi_cs_n !== 1'b1) begin miss_cnt++; $display("FAIL cs_latency0 got %b want 1", spi_cs_n); end
    @(negedge clk_sys);
    vec_cnt++; if (spi_cs_n !== 1'b0) begin miss_cnt++; $display("FAIL cs_latency1 got %b want 0", spi_cs_n); end
    send_byte(8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    vec_cnt++; if (obs_rx !== 8'h01) begin miss_cnt++; $display("FAIL resp_rx got %h want 01", obs_rx); end
    vec_cnt++; if (obs_cs_hi !== 0) begin miss_cnt++; $display("FAIL cs_held_in_byte got %0d high samples want 0", obs_cs_hi); end
    @(negedge clk_sys);
    vec_cnt++; if (spi_cs_n !== 1'b1) begin miss_cnt++; $display("FAIL cs_release got %b want 1", spi_cs_n); end
  endtask

  task automatic test_back_to_back();
    int bad;
    miso_mode = 2'd1;
    cs_req    = 1'b1;
    @(negedge clk_sys);
    send_byte(8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
    vec_cnt++; if (obs_rx !== 8'h00) begin miss_cnt++; $display("FAIL b2b_rx0 got %h want 00", obs_rx); end
    vec_cnt++; if (obs_ready_after !== 1'b1) begin miss_cnt++; $display("FAIL b2b_gap_ready got %b want 1", obs_ready_after); end
    vec_cnt++; if (obs_sck_after !== 1'b0) begin miss_cnt++; $display("FAIL b2b_gap_sck got %b want 0", obs_sck_after); end
    send_byte(8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    vec_cnt++; if (obs_wait !== 0) begin miss_cnt++; $display("FAIL b2b_accept_wait got %0d want 0", obs_wait); end
    vec_cnt++; if (obs_rx !== 8'hFF) begin miss_cnt++; $display("FAIL b2b_rx1 got %h want ff", obs_rx); end
    vec_cnt++; if (obs_latency !== model_latency(HF)) begin
      miss_cnt++; $display("FAIL b2b_latency got %0d want %0d", obs_latency, model_latency(HF));
    end
    bad = 0;
    for (int i = 0; i < 8; i++) if (obs_rise_t[i] != model_rise(HF, i)) bad++;
    vec_cnt++; if (bad !== 0 || obs_rises !== 8) begin
      miss_cnt++; $display("FAIL b2b_sck got %0d bad/%0d rises want 0/8", bad, obs_rises);
    end
  endtask

  task automatic test_reset_mid_byte();
    int   rises;
    int   rxv_seen;
    logic prev_sck;
    logic [7:0] d;
    miso_mode = 2'd1;
    cs_req    = 1'b1;
    @(negedge clk_sys);
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    prev_sck = spi_clk;
    @(posedge clk_sys);
    @(negedge clk_sys);
    tx_valid = 1'b0;
    rises = 0; rxv_seen = 0;
    for (int k = 0; k < 200 && rises < 4; k++) begin
      if (k > 0) @(negedge clk_sys);
      if (spi_clk === 1'b1 && prev_sck === 1'b0) rises++;
      if (rx_valid === 1'b1) rxv_seen++;
      prev_sck = spi_clk;
    end
    vec_cnt++; if (rises !== 4) begin miss_cnt++; $display("FAIL mid_reach_rise4 got %0d want 4", rises); end
    reset_n = 1'b0;
    #1;
    vec_cnt++; if (spi_clk !== 1'b0 || spi_mosi !== 1'b1 || spi_cs_n !== 1'b1) begin
      miss_cnt++; $display("FAIL mid_rst_pins got sck=%b mosi=%b cs_n=%b want 0/1/1", spi_clk, spi_mosi, spi_cs_n);
    end
    vec_cnt++; if (tx_ready !== 1'b1 || rx_data !== 8'hFF) begin
      miss_cnt++; $display("FAIL mid_rst_state got ready=%b rx=%h want 1/ff", tx_ready, rx_data);
    end
    repeat (3) begin @(negedge clk_sys); if (rx_valid === 1'b1) rxv_seen++; end
    reset_n = 1'b1;
    repeat (3) begin @(negedge clk_sys); if (rx_valid === 1'b1) rxv_seen++; end
    vec_cnt++; if (rxv_seen !== 0) begin miss_cnt++; $display("FAIL mid_no_rx_valid got %0d pulses want 0", rxv_seen); end
    d = 8'($urandom);
    send_byte(d, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    vec_cnt++; if (obs_rx !== d || obs_latency !== model_latency(HF)) begin
      miss_cnt++; $display("FAIL mid_next_byte got %h/%0d want %h/%0d", obs_rx, obs_latency, d, model_latency(HF));
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic [7:0] exp_rx;
    logic       f;
    int         h;
    int         bad;
    cs_req = 1'b1;
    for (int n = 0; n < 12; n++) begin
      d = 8'($urandom);
      f = ($urandom_range(0, 5) != 0);
      h = f ? HF : HS;
      if ($urandom_range(0, 1) == 0) begin
        miso_mode = 2'd1;
        exp_rx    = d;
      end else begin
        miso_mode = 2'd2;
        resp_byte = 8'($urandom);
        exp_rx    = resp_byte;
      end
      @(negedge clk_sys);
      send_byte(d, f, 1'b0, 8'h00, 1'b0, 1'b0);
      vec_cnt++; if (obs_rx !== exp_rx) begin
        miss_cnt++; $display("FAIL rnd_rx[%0d] got %h want %h", n, obs_rx, exp_rx);
      end
      vec_cnt++; if (obs_latency !== model_latency(h)) begin
        miss_cnt++; $display("FAIL rnd_latency[%0d] got %0d want %0d", n, obs_latency, model_latency(h));
      end
      bad = 0;
      for (int i = 0; i < 8; i++) begin
        if (obs_rise_t[i] != model_rise(h, i)) bad++;
        if (obs_mosi_rise[i] !== d[7 - i]) bad++;
      end
      vec_cnt++; if (bad !== 0 || obs_rises !== 8) begin
        miss_cnt++; $display("FAIL rnd_wave[%0d] got %0d bad/%0d rises want 0/8", n, bad, obs_rises);
      end
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    test_reset();
    test_loopback();
    test_slow_rate();
    test_responder_cs();
    test_back_to_back();
    test_reset_mid_byte();
    test_random();
    repeat (4) @(negedge clk_sys);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule : tb_sd_spi_master
